// File: rtl/pipe_cla_add_if.sv
// Operand/result bus of the pipelined carry-lookahead adder.
// Both sides use valid/ready: a beat moves only on a clock edge where valid and ready are both 1;
// the source holds payload and valid until that edge, and ready never depends on the same side's valid.
interface pipe_cla_add_if #(
    parameter int WIDTH = 96
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a_in;
    logic [WIDTH-1:0] b_in;
    logic             c_in;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             c_out;
    logic             ovf;

    modport master (
        output in_valid, a_in, b_in, c_in, sub, out_ready,
        input  in_ready, out_valid, sum, c_out, ovf
    );

    modport slave (
        input  in_valid, a_in, b_in, c_in, sub, out_ready,
        output in_ready, out_valid, sum, c_out, ovf
    );
endinterface

// File: rtl/pipe_cla_add.sv
// Pipelined adder/subtractor: one SEG_WIDTH-bit carry-lookahead segment per stage,
// with the inter-segment carry registered and operands/partial sums skewed through the pipe.
module pipe_cla_add #(
    parameter int WIDTH     = 96,
    parameter int SEG_WIDTH = 24
) (
    input  logic           clk,
    input  logic           rst,
    pipe_cla_add_if.slave  bus
);
    localparam int NSEG = WIDTH / SEG_WIDTH;

    // Parallel-prefix (Kogge-Stone style) group generate/propagate inside one segment.
    function automatic logic [SEG_WIDTH:0] cla_seg(
        input logic [SEG_WIDTH-1:0] a,
        input logic [SEG_WIDTH-1:0] b,
        input logic                 ci
    );
        logic [SEG_WIDTH-1:0] p;
        logic [SEG_WIDTH-1:0] gg;
        logic [SEG_WIDTH-1:0] pp;
        logic [SEG_WIDTH-1:0] c;
        p  = a ^ b;
        gg = a & b;
        pp = p;
        for (int d = 1; d < SEG_WIDTH; d = d * 2) begin
            for (int i = SEG_WIDTH - 1; i >= d; i--) begin
                gg[i] = gg[i] | (pp[i] & gg[i-d]);
                pp[i] = pp[i] & pp[i-d];
            end
        end
        c[0] = ci;
        for (int i = 1; i < SEG_WIDTH; i++) begin
            c[i] = gg[i-1] | (pp[i-1] & ci);
        end
        return {gg[SEG_WIDTH-1] | (pp[SEG_WIDTH-1] & ci), p ^ c};
    endfunction

    logic             en;
    logic [WIDTH-1:0] b_eff;
    logic             cin0;

    logic [NSEG-1:0]  v_q;
    logic [NSEG-1:0]  cy_q;
    logic [NSEG-1:0]  cy_d;
    logic [WIDTH-1:0] x_q [NSEG];
    logic [WIDTH-1:0] y_q [NSEG];
    logic [WIDTH-1:0] x_d [NSEG];
    logic [WIDTH-1:0] y_d [NSEG];
    logic [WIDTH-1:0] sum_q;
    logic             ovf_q;
    logic             ovf_d;

    assign en           = !v_q[NSEG-1] || bus.out_ready;
    assign bus.in_ready = en;
    assign b_eff        = bus.sub ? ~bus.b_in : bus.b_in;
    assign cin0         = bus.sub | bus.c_in;

    // x carries {unprocessed A segments, finished sum segments}; y carries the (inverted-for-sub) B.
    for (genvar k = 0; k < NSEG; k++) begin : g_stage
        logic [SEG_WIDTH-1:0] sa;
        logic [SEG_WIDTH-1:0] sb;
        logic [SEG_WIDTH-1:0] ss;
        logic                 ci;
        logic                 co;
        logic [WIDTH-1:0]     xb;
        logic [WIDTH-1:0]     yb;
        logic [WIDTH-1:0]     xn;

        if (k == 0) begin : g_first
            assign xb = bus.a_in;
            assign yb = b_eff;
            assign ci = cin0;
        end else begin : g_next
            assign xb = x_q[k-1];
            assign yb = y_q[k-1];
            assign ci = cy_q[k-1];
        end

        assign sa        = xb[k*SEG_WIDTH +: SEG_WIDTH];
        assign sb        = yb[k*SEG_WIDTH +: SEG_WIDTH];
        assign {co, ss}  = cla_seg(sa, sb, ci);

        always_comb begin
            xn = xb;
            xn[k*SEG_WIDTH +: SEG_WIDTH] = ss;
        end

        assign x_d[k]  = xn;
        assign y_d[k]  = yb;
        assign cy_d[k] = co;

        if (k == NSEG - 1) begin : g_last
            // Carry into the MSB recovered from its sum bit; overflow is that XOR carry-out.
            assign ovf_d = co ^ (ss[SEG_WIDTH-1] ^ sa[SEG_WIDTH-1] ^ sb[SEG_WIDTH-1]);
        end
    end

    always_ff @(posedge clk) begin
        if (en) begin
            for (int k = 0; k < NSEG - 1; k++) begin
                x_q[k] <= x_d[k];
                y_q[k] <= y_d[k];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v_q   <= '0;
            cy_q  <= '0;
            sum_q <= '0;
            ovf_q <= 1'b0;
        end else if (en) begin
            v_q[0] <= bus.in_valid;
            for (int k = 1; k < NSEG; k++) begin
                v_q[k] <= v_q[k-1];
            end
            cy_q  <= cy_d;
            sum_q <= x_d[NSEG-1];
            ovf_q <= ovf_d;
        end
    end

    assign bus.out_valid = v_q[NSEG-1];
    assign bus.sum       = sum_q;
    assign bus.c_out     = cy_q[NSEG-1];
    assign bus.ovf       = ovf_q;
endmodule

// File: tb/tb_pipe_cla_add.sv
// Bench for pipe_cla_add: 96/24 streaming with a scoreboard, plus 64/16 and 32/32 builds.
module tb_pipe_cla_add;
    localparam int NSEG96 = 4;
    localparam logic [95:0] ALL1 = {96{1'b1}};
    localparam logic [95:0] MSB1 = {1'b1, 95'b0};
    localparam logic [95:0] MAXP = {1'b0, {95{1'b1}}};

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    pipe_cla_add_if #(.WIDTH(96)) i96 ();
    pipe_cla_add_if #(.WIDTH(64)) i64 ();
    pipe_cla_add_if #(.WIDTH(32)) i32 ();

    pipe_cla_add #(.WIDTH(96), .SEG_WIDTH(24)) dut96 (.clk(clk), .rst(rst), .bus(i96.slave));
    pipe_cla_add #(.WIDTH(64), .SEG_WIDTH(16)) dut64 (.clk(clk), .rst(rst), .bus(i64.slave));
    pipe_cla_add #(.WIDTH(32), .SEG_WIDTH(32)) dut32 (.clk(clk), .rst(rst), .bus(i32.slave));

    // ---------------- scoreboard state ----------------
    logic [97:0] exp_q[$];
    int          cyc_q[$];
    bit          rand_ready = 1'b0;
    bit          lat_chk    = 1'b0;
    logic        hold_prev  = 1'b0;
    logic [97:0] prev_out;
    logic [97:0] mon_exp;
    int          mon_acc;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic timeout_fail(input string tag);
        checks++;
        errors++;
        $error("FAIL %s observed=timeout expected=handshake", tag);
    endtask

    // Reference: plain wide addition, overflow from operand/result sign rule. Returns {ovf, c_out, sum}.
    function automatic logic [97:0] model(input logic [95:0] a, input logic [95:0] b,
                                          input logic c, input logic s, input int w);
        logic [95:0] mask;
        logic [95:0] bb;
        logic [95:0] sm;
        logic [96:0] full;
        logic        co;
        logic        ov;
        mask = (w == 96) ? ALL1 : ((96'd1 << w) - 96'd1);
        bb   = (s ? ~b : b) & mask;
        full = {1'b0, a & mask} + {1'b0, bb} + 97'(s ? 1'b1 : c);
        sm   = full[95:0] & mask;
        co   = full[w];
        ov   = (a[w-1] == bb[w-1]) && (sm[w-1] != a[w-1]);
        return {ov, co, sm};
    endfunction

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
        if (rand_ready) i96.out_ready = 1'($urandom_range(0, 1));
    endtask

    task automatic send96(input logic [95:0] a, input logic [95:0] b, input logic c,
                          input logic s, input logic [97:0] exp);
        int tries = 0;
        bit done  = 1'b0;
        i96.a_in     = a;
        i96.b_in     = b;
        i96.c_in     = c;
        i96.sub      = s;
        i96.in_valid = 1'b1;
        while (!done) begin
            @(negedge clk);
            if (i96.in_ready) begin
                exp_q.push_back(exp);
                cyc_q.push_back(cyc);
                done = 1'b1;
            end else if (++tries > 100) begin
                timeout_fail("send96_accept");
                done = 1'b1;
            end
            step();
        end
        i96.in_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 300) begin
            step();
            n++;
        end
        if (exp_q.size() != 0) timeout_fail("drain");
    endtask

    task automatic beat64(input logic [63:0] a, input logic [63:0] b, input logic c,
                          input logic s, input logic [97:0] exp);
        int n = 1;
        i64.a_in = a; i64.b_in = b; i64.c_in = c; i64.sub = s; i64.in_valid = 1'b1;
        @(negedge clk);
        chk("in_ready64", i64.in_ready, 1'b1);
        step();
        i64.in_valid = 1'b0;
        @(negedge clk);
        while (!i64.out_valid && n < 20) begin
            step();
            @(negedge clk);
            n++;
        end
        chk("latency64", n, 4);
        chk("sum64", i64.sum, exp[63:0]);
        chk("cout64", i64.c_out, exp[96]);
        chk("ovf64", i64.ovf, exp[97]);
        step();
    endtask

    task automatic beat32(input logic [31:0] a, input logic [31:0] b, input logic c,
                          input logic s, input logic [97:0] exp);
        int n = 1;
        i32.a_in = a; i32.b_in = b; i32.c_in = c; i32.sub = s; i32.in_valid = 1'b1;
        @(negedge clk);
        chk("in_ready32", i32.in_ready, 1'b1);
        step();
        i32.in_valid = 1'b0;
        @(negedge clk);
        while (!i32.out_valid && n < 20) begin
            step();
            @(negedge clk);
            n++;
        end
        chk("latency32", n, 1);
        chk("sum32", i32.sum, exp[31:0]);
        chk("cout32", i32.c_out, exp[96]);
        chk("ovf32", i32.ovf, exp[97]);
        step();
    endtask

    // ---------------- output monitor (96-bit build) ----------------
    always @(negedge clk) begin
        if (rst) begin
            hold_prev <= 1'b0;
        end else begin
            chk("in_ready_rule", i96.in_ready, !i96.out_valid || i96.out_ready);
            if (hold_prev) chk("stall_hold", {i96.out_valid, i96.ovf, i96.c_out, i96.sum}, {1'b1, prev_out});
            if (i96.out_valid && i96.out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_beat", i96.out_valid, 1'b0);
                end else begin
                    mon_exp = exp_q.pop_front();
                    mon_acc = cyc_q.pop_front();
                    chk("result96", {i96.ovf, i96.c_out, i96.sum}, mon_exp);
                    if (lat_chk) chk("latency96", cyc - mon_acc, NSEG96);
                end
            end
            hold_prev <= i96.out_valid && !i96.out_ready;
            prev_out  <= {i96.ovf, i96.c_out, i96.sum};
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=no_finish expected=finish");
        $fatal(1, "watchdog expired");
    end

    // ---------------- directed sequence ----------------
    initial begin
        logic [95:0] ra, rb;
        logic        rc, rs;
        int          n;

        rst = 1'b1;
        i96.in_valid = 1'b0; i96.a_in = '0; i96.b_in = '0; i96.c_in = 1'b0; i96.sub = 1'b0; i96.out_ready = 1'b1;
        i64.in_valid = 1'b0; i64.a_in = '0; i64.b_in = '0; i64.c_in = 1'b0; i64.sub = 1'b0; i64.out_ready = 1'b1;
        i32.in_valid = 1'b0; i32.a_in = '0; i32.b_in = '0; i32.c_in = 1'b0; i32.sub = 1'b0; i32.out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        @(negedge clk);
        chk("reset_out_valid96", i96.out_valid, 1'b0);
        chk("reset_in_ready96", i96.in_ready, 1'b1);
        chk("reset_outs96", {i96.ovf, i96.c_out, i96.sum}, 98'd0);
        chk("reset_out_valid64", i64.out_valid, 1'b0);
        chk("reset_out_valid32", i32.out_valid, 1'b0);
        step();

        // Hand-computed vectors, back to back, out_ready held high.
        lat_chk = 1'b1;
        send96(ALL1, 96'd0, 1'b1, 1'b0, {1'b0, 1'b1, 96'd0});
        send96(96'd0, 96'd1, 1'b0, 1'b1, {1'b0, 1'b0, ALL1});
        send96(MSB1, 96'd1, 1'b0, 1'b1, {1'b1, 1'b1, MAXP});
        send96(MAXP, 96'd1, 1'b0, 1'b0, {1'b1, 1'b0, MSB1});
        send96(MSB1, MSB1, 1'b0, 1'b0, {1'b1, 1'b1, 96'd0});
        send96(96'd5, 96'd3, 1'b1, 1'b1, {1'b0, 1'b1, 96'd2});
        send96(96'hFF_FFFF, 96'd1, 1'b0, 1'b0, {1'b0, 1'b0, 96'h100_0000});
        send96(ALL1, ALL1, 1'b1, 1'b0, {1'b0, 1'b1, ALL1});
        drain();

        // 20 random back-to-back beats with mixed add/sub.
        for (int i = 0; i < 20; i++) begin
            ra = {$urandom, $urandom, $urandom};
            rb = {$urandom, $urandom, $urandom};
            rc = 1'($urandom_range(0, 1));
            rs = 1'($urandom_range(0, 1));
            send96(ra, rb, rc, rs, model(ra, rb, rc, rs, 96));
        end
        drain();

        // Random downstream back-pressure with occasional input bubbles.
        lat_chk    = 1'b0;
        rand_ready = 1'b1;
        for (int i = 0; i < 30; i++) begin
            ra = {$urandom, $urandom, $urandom};
            rb = {$urandom, $urandom, $urandom};
            rc = 1'($urandom_range(0, 1));
            rs = 1'($urandom_range(0, 1));
            send96(ra, rb, rc, rs, model(ra, rb, rc, rs, 96));
            if ($urandom_range(0, 3) == 0) step();
        end
        drain();
        rand_ready    = 1'b0;
        i96.out_ready = 1'b1;
        step();

        // Reset with three beats in flight and a stalled result at the output.
        i96.out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            ra = {$urandom, $urandom, $urandom};
            send96(ra, 96'd7, 1'b0, 1'b0, model(ra, 96'd7, 1'b0, 1'b0, 96));
        end
        n = 0;
        while (!i96.out_valid && n < 10) begin
            step();
            n++;
        end
        chk("pre_reset_valid", i96.out_valid, 1'b1);
        rst = 1'b1;
        #1;
        chk("rst_out_valid", i96.out_valid, 1'b0);
        chk("rst_in_ready", i96.in_ready, 1'b1);
        chk("rst_outs", {i96.ovf, i96.c_out, i96.sum}, 98'd0);
        exp_q.delete();
        cyc_q.delete();
        i96.out_ready = 1'b1;
        step();
        rst = 1'b0;
        repeat (5) step();
        chk("post_reset_idle", i96.out_valid, 1'b0);
        lat_chk = 1'b1;
        send96(MSB1, 96'd1, 1'b1, 1'b1, {1'b1, 1'b1, MAXP});
        drain();

        // Narrower builds: 4-stage 64-bit and single-stage 32-bit.
        beat64(64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b1, 1'b0, {1'b0, 1'b1, 96'd0});
        beat64(64'd0, 64'd1, 1'b0, 1'b1, {1'b0, 1'b0, 32'd0, 64'hFFFF_FFFF_FFFF_FFFF});
        for (int i = 0; i < 3; i++) begin
            ra = {32'd0, $urandom, $urandom};
            rb = {32'd0, $urandom, $urandom};
            rc = 1'($urandom_range(0, 1));
            rs = 1'($urandom_range(0, 1));
            beat64(ra[63:0], rb[63:0], rc, rs, model(ra, rb, rc, rs, 64));
        end
        beat32(32'd0, 32'd1, 1'b0, 1'b1, {1'b0, 1'b0, 64'd0, 32'hFFFF_FFFF});
        beat32(32'h8000_0000, 32'd1, 1'b0, 1'b1, {1'b1, 1'b1, 64'd0, 32'h7FFF_FFFF});
        for (int i = 0; i < 3; i++) begin
            ra = {64'd0, $urandom};
            rb = {64'd0, $urandom};
            rc = 1'($urandom_range(0, 1));
            rs = 1'($urandom_range(0, 1));
            beat32(ra[31:0], rb[31:0], rc, rs, model(ra, rb, rc, rs, 32));
        end

        // ---------------- final report ----------------
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/pipe_cla_add.md
PIPE_CLA_ADD -- requirements
Module: pipe_cla_add

Interface
REQ-001 Parameter WIDTH, default 96, total operand/sum width in bits.
REQ-002 Parameter SEG_WIDTH, default 24, bits added per pipeline stage; WIDTH SHALL be an integer multiple of SEG_WIDTH; NSEG = WIDTH/SEG_WIDTH (default 4).
REQ-003 clk  input  1  single clock; all state on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 in_valid  input  1  operand beat present.
REQ-006 in_ready  output  1  block accepts a beat this cycle.
REQ-007 a_in  input  WIDTH  operand A.
REQ-008 b_in  input  WIDTH  operand B.
REQ-009 c_in  input  1  carry-in (add mode only).
REQ-010 sub  input  1  0 = A+B+c_in, 1 = A-B (A + ~B + 1, c_in ignored).
REQ-011 out_valid  output  1  result beat present.
REQ-012 out_ready  input  1  downstream accepts result.
REQ-013 sum  output  WIDTH  result, registered.
REQ-014 c_out  output  1  carry out of bit WIDTH-1 (for sub: 1 = no borrow).
REQ-015 ovf  output  1  signed two's-complement overflow of the operation.

Function
REQ-016 Beat accepted when in_valid && in_ready; result delivered when out_valid && out_ready.
REQ-017 Stage k (k=0..NSEG-1) SHALL add segment k with carry-lookahead logic using the carry registered by stage k-1 (stage 0 uses c_in, or 1 when sub); segment sums of lower segments and unprocessed upper operand segments SHALL travel skewed in pipeline registers.
REQ-018 Latency SHALL be exactly NSEG cycles from acceptance to out_valid with out_ready held high; throughput one beat per cycle.
REQ-019 Pipeline advance enable en = !out_valid || out_ready; in_ready SHALL equal en (combinational from out_valid/out_ready only, not from in_valid).
REQ-020 When en=0 every stage register, valid bit and carry SHALL hold; sum/c_out/ovf SHALL remain stable while out_valid=1 and out_ready=0.
REQ-021 When en=1, bubbles (in_valid=0) SHALL propagate as valid=0 beats; data content of invalid beats is don't-care.
REQ-022 Result SHALL equal (A + B + c_in) mod 2^WIDTH, or (A - B) mod 2^WIDTH for sub, with c_out the bit-WIDTH carry and ovf = carry into MSB XOR carry out of MSB.
REQ-023 The sub bit SHALL be captured per beat; mixed add/sub beats back-to-back SHALL each compute independently.
REQ-024 Simultaneous acceptance and delivery in one cycle SHALL be supported with no beat loss or duplication.

Reset
REQ-025 On rst=1, all valid bits, stage carries, sum, c_out and ovf SHALL clear to 0 asynchronously; out_valid=0, in_ready=1 from the first cycle after rst deasserts.
REQ-026 Beats in flight when rst asserts SHALL be discarded; no result for them SHALL appear.
REQ-027 Datapath registers other than those in REQ-025 MAY be unreset.

Verification
REQ-028 Defaults, out_ready=1, one beat A=0xFFFF..FF (96 bits all 1), B=0, c_in=1, sub=0 -> 4 cycles later out_valid=1, sum=0, c_out=1, ovf=0 (full-length carry ripple across all segments).
REQ-029 sub=1, A=0, B=1 -> sum=all 1s, c_out=0, ovf=0; sub=1, A=0x8000..00, B=1 -> sum=0x7FFF..FF, c_out=1, ovf=1.
REQ-030 Stream 20 random back-to-back beats with mixed sub, out_ready=1 -> 20 results in order, one per cycle, each matching reference model, latency 4.
REQ-031 Stream with out_ready toggled randomly (50%) -> no loss/duplication, outputs stable during stall, in_ready==(!out_valid||out_ready) every cycle.
REQ-032 Assert rst for 1 cycle with 3 beats in flight -> out_valid=0 immediately; next accepted beat emerges after exactly 4 cycles with correct value.
REQ-033 WIDTH=64, SEG_WIDTH=16 and WIDTH=32, SEG_WIDTH=32 builds -> latency 4 and 1 respectively, random add/sub beats match model.
